// File: rtl/i2c_slave.sv
// I2C target with a byte register bank: START/STOP decode, 7-bit address match, pointer-then-data writes, auto-increment reads.
// Bits act 3-4 clks after the SCL edge; SCL is never stretched, so clk must run at least 8x SCL.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter int         PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_o,
    output logic             sda_t,
    output logic             busy,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_reg,
    output logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] host_raddr,
    output logic [7:0]       host_rdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WDATA, S_WACK, S_RDATA, S_RACK, S_IDLE_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_t_q, sda_t_d;
    logic             busy_q, busy_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0] wr_reg_q, wr_reg_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       regs_q [NUM_REGS];

    logic scl_m_q, scl_s_q, scl_h_q, sda_m_q, sda_s_q, sda_h_q;
    logic scl_rise, scl_fall, start_det, stop_det, byte_done, addr_hit;
    logic [7:0] byte_in, rd_byte;

    // Synchronizers come out of reset at the idle-bus level so release never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {scl_m_q, scl_s_q, scl_h_q} <= 3'b111;
            {sda_m_q, sda_s_q, sda_h_q} <= 3'b111;
        end else begin
            {scl_m_q, scl_s_q, scl_h_q} <= {scl_i, scl_m_q, scl_s_q};
            {sda_m_q, sda_s_q, sda_h_q} <= {sda_i, sda_m_q, sda_s_q};
        end
    end

    assign scl_rise  = scl_s_q & ~scl_h_q;
    assign scl_fall  = ~scl_s_q & scl_h_q;
    assign start_det = scl_s_q & scl_h_q & sda_h_q & ~sda_s_q;
    assign stop_det  = scl_s_q & scl_h_q & ~sda_h_q & sda_s_q;
    assign byte_in   = {shift_q[6:0], sda_s_q};
    assign byte_done = scl_rise & (cnt_q == 3'd7);
    assign addr_hit  = (byte_in[7:1] == SLAVE_ADDR);
    assign rd_byte   = regs_q[ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // In the ACK states, sda_t_q low marks the second half of the slot (ACK already driven)
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = S_ADDR;
        end else if (stop_det) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR:         if (byte_done) state_d = addr_hit ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK:     if (scl_fall && !sda_t_q) state_d = shift_q[0] ? S_RDATA : S_PTR;
                S_PTR, S_WDATA: if (byte_done) state_d = S_WACK;
                S_WACK:         if (scl_fall && !sda_t_q) state_d = S_WDATA;
                S_RDATA:        if (scl_rise && cnt_q == 3'd0) state_d = S_RACK;
                S_RACK:         if (scl_rise) state_d = sda_s_q ? S_IDLE_WAIT : S_RDATA;
                default:        state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_t_d     = sda_t_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        if (start_det) begin
            cnt_d   = 3'd0;
            sda_t_d = 1'b1;
            busy_d  = 1'b0;
        end else if (stop_det) begin
            sda_t_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                    end
                    if (byte_done && state_q == S_ADDR && addr_hit) busy_d = 1'b1;
                    if (byte_done && state_q == S_PTR) ptr_d = byte_in[PTR_W-1:0];
                    if (byte_done && state_q == S_WDATA) begin
                        wr_strobe_d = 1'b1;
                        wr_reg_d    = ptr_q;
                        wr_data_d   = byte_in;
                        ptr_d       = ptr_q + PTR_W'(1);
                    end
                end
                S_ADDR_ACK, S_WACK: begin
                    if (scl_fall && sda_t_q) begin
                        sda_t_d = 1'b0;
                    end else if (scl_fall) begin
                        sda_t_d = 1'b1;
                        cnt_d   = 3'd0;
                        // Read: the ACK-release edge also launches bit 7 of the first byte
                        if (state_q == S_ADDR_ACK && shift_q[0]) begin
                            sda_t_d = rd_byte[7];
                            shift_d = {rd_byte[6:0], 1'b1};
                            ptr_d   = ptr_q + PTR_W'(1);
                            cnt_d   = 3'd1;
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        sda_t_d = shift_q[7];
                        shift_d = {shift_q[6:0], 1'b1};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
                S_RACK: begin
                    if (scl_fall) sda_t_d = 1'b1;
                    if (scl_rise && !sda_s_q) begin
                        shift_d = rd_byte;
                        ptr_d   = ptr_q + PTR_W'(1);
                        cnt_d   = 3'd0;
                    end
                end
                default: sda_t_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_t_q     <= sda_t_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // The bank updates at the end of the strobe cycle, so host reads during the strobe see the old byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_strobe_q) begin
            regs_q[wr_reg_q] <= wr_data_q;
        end
    end

    assign sda_o      = 1'b0;
    assign sda_t      = sda_t_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_reg     = wr_reg_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = regs_q[host_raddr];

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) endpoint with an internal byte-wide register bank; the responder counterpart of the team's I2C master.
- Decodes START/STOP/repeated START, matches a 7-bit address and ACKs it.
- Writes: first data byte is the register pointer; following bytes are written at the pointer with auto-increment.
- Reads: returns register contents from the current pointer with auto-increment.
- Sits beside the master in the FPGA; the top level wraps its SDA pins in the same IOBUF style.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address matched against the first byte after START.
- NUM_REGS, 16, number of 8-bit registers, power of 2, 2..256.
- PTR_W, $clog2(NUM_REGS), pointer width. Derived; do not override.

Ports:
- clk  input  1  system clock; must be >= 8x SCL frequency.
- rst  input  1  asynchronous active-high reset.
- scl_i  input  1  SCL line sample, asynchronous to clk.
- sda_i  input  1  SDA line sample, from the IOBUF output.
- sda_o  output  1  SDA drive value, constant 0 (open drain).
- sda_t  output  1  IOBUF tristate: 1 = release, 0 = pull low.
- busy  output  1  high from an address match until STOP or START.
- wr_strobe  output  1  one-clk pulse per register written.
- wr_reg  output  PTR_W  register index written, valid with wr_strobe.
- wr_data  output  8  byte written, valid with wr_strobe.
- host_raddr  input  PTR_W  host-side read index.
- host_rdata  output  8  regs[host_raddr], combinational.

Behaviour:
Reset:
- Asynchronous, active-high, in every flop.
- sda_t=1, busy=0, wr_strobe=0, wr_reg=0, wr_data=0, pointer=0, all regs=0, state=IDLE.
- Reset mid-transfer releases SDA immediately (asynchronous).

Input conditioning and line events:
- scl_i and sda_i each pass a 2-flop synchronizer, then one history flop for edge detection.
- START = sync SDA falls while sync SCL is high. Valid in any state: goes to ADDR, bit counter cleared, sda_t=1.
- STOP = sync SDA rises while sync SCL is high. Valid in any state: goes to IDLE, sda_t=1, busy=0. Pointer is retained.
- SDA is sampled on the sync SCL rising edge. SDA drive changes only on the sync SCL falling edge.
- The event detectors take priority over bit processing in the same clk.

Bit counter:
- 3 bits; counts 8 data bits MSB first; the 9th SCL cycle is the ACK slot.

State machine:
- IDLE: ignores all bits; waits for START.
- ADDR: shifts 8 bits. If addr[7:1]==SLAVE_ADDR, go to ADDR_ACK and set busy=1. Otherwise keep SDA released (NACK) and go to IDLE.
- ADDR_ACK: on the falling edge after bit 8, sda_t=0 for one SCL period; release on the next falling edge.
  - R/W=0 goes to PTR.
  - R/W=1: load shift_reg=regs[ptr], pointer++, go to RDATA.
- PTR: shift 8 bits; pointer = byte[PTR_W-1:0] (upper bits discarded); ACK; go to WDATA.
- WDATA: shift 8 bits, then:
  - regs[ptr]=byte.
  - wr_strobe pulse with wr_reg=ptr and wr_data=byte, in the clk following the 8th rising edge.
  - pointer++, ACK, remain in WDATA.
- RDATA:
  - Drive each bit on the SCL falling edge: bit=0 gives sda_t=0, bit=1 gives sda_t=1.
  - After 8 bits, release SDA and go to RACK.
- RACK: sample the master's ACK on the SCL rising edge.
  - ACK (0): load regs[ptr], pointer++, go to RDATA.
  - NACK (1): go to IDLE_WAIT. IDLE_WAIT holds SDA released until STOP/START; busy stays 1.

Arithmetic:
- Pointer increments modulo NUM_REGS (wraps NUM_REGS-1 -> 0).

Boundary conditions:
- A repeated START after PTR gives a combined write-pointer/read transaction; the pointer is kept.
- A STOP in the middle of a byte discards the partial byte; no wr_strobe.
- A host read on the same clk as wr_strobe returns the old value; the new value is visible the next clk.
- No clock stretching: SCL is never driven.

Test Plan:
- Write: START, 0xA0, 0x03, 0x11, 0x22, STOP -> ACKs on all 4 bytes; wr_strobe (3,0x11) then (4,0x22); host_raddr=4 reads 0x22.
- Combined read: START 0xA0 0x03, repeated START 0xA1, master ACK then NACK, STOP -> slave drives 0x11 then 0x22; pointer=5; SDA released after the NACK.
- Address mismatch: START 0xA2 0x55 STOP -> sda_t stays 1 throughout; no wr_strobe; busy stays 0.
- Wrap: pointer 0x0F, write 0xAA, 0xBB -> regs[15]=0xAA, regs[0]=0xBB. Pointer byte 0x35 -> ptr=5.
- Abort: STOP after 4 bits of a data byte -> no wr_strobe, state IDLE; next transaction works normally.
- Reset: assert rst while sda_t=0 during ACK -> sda_t=1 within the same clk; all regs=0; busy=0.
